// File: rtl/vernam_pkg.sv
// vernam_pkg: keystream definition shared by the encrypt and decrypt ends.
// Both sides must agree on the LFSR taps and reset seed, so they live here.
package vernam_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Feedback taps on bits 7, 5, 4 and 3 of the left-shifting Fibonacci LFSR
  localparam logic [7:0] LFSR_TAPS           = 8'hB8;
  localparam logic [7:0] VERNAM_SEED_DEFAULT = 8'h01;

  // One LFSR step: shift left, feed the XOR of the tapped bits into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vernam_fifo.sv
// vernam_fifo: 8-bit show-ahead FIFO with a registered head byte.
// The head register is refreshed from storage on a pop, or loaded directly
// from the write data when the pushed byte becomes the new head.
module vernam_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [7:0]    head_reg, head_next;
  logic [AW-1:0] rd_ptr_plus1;
  logic          do_push, do_pop;

  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign do_pop       = pop && !empty && !flush;
  // A full FIFO still takes a write when the head leaves in the same cycle
  assign do_push      = push && (!full || do_pop) && !flush;
  assign rd_ptr_plus1 = rd_ptr_reg + AW'(1);
  assign rd_data      = head_reg;

  // Next occupancy and next head byte
  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
    if (empty) begin
      if (do_push) head_next = wr_data;
    end else if (do_pop) begin
      if (count_reg == CW'(1)) begin
        if (do_push) head_next = wr_data;
      end else begin
        head_next = mem[rd_ptr_plus1];
      end
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= 8'h00;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_plus1;
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end

endmodule

// File: rtl/vernam_decrypt.sv
// vernam_decrypt: receive-side Vernam stream decryptor.
// Regenerates the keystream from a shared seed, XORs it onto incoming
// ciphertext and queues the plaintext for the consumer at one byte per clock.
// Optional feature macro: VERNAM_DEC_CHECKSUM_EN (running XOR of plaintext).
module vernam_decrypt
  import vernam_pkg::*;
#(
  parameter int         DEPTH        = 4,
  parameter logic [7:0] SEED_DEFAULT = VERNAM_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_load,
  input  logic [7:0]  key_seed,
  input  logic        key_clear,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] byte_count,
  output logic [7:0]  checksum
);

  state_t      state_reg;
  logic [7:0]  lfsr_reg;
  logic [15:0] byte_count_reg;
  logic        fifo_full, fifo_empty;
  logic        accept;
  logic [7:0]  plain;
  logic [7:0]  seed_fixed;

  assign in_ready   = (state_reg == RUN) && !fifo_full && !key_clear;
  assign accept     = in_valid && in_ready;
  assign plain      = in_data ^ lfsr_reg;
  // An all-zero seed would lock the LFSR, so it is replaced with 8'h01
  assign seed_fixed = (key_seed == 8'h00) ? 8'h01 : key_seed;
  assign out_valid  = !fifo_empty;
  assign byte_count = byte_count_reg;

  // Key state, keystream generator and accepted-byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      lfsr_reg       <= SEED_DEFAULT;
      byte_count_reg <= 16'd0;
    end else if (key_clear) begin
      state_reg      <= IDLE;
      byte_count_reg <= 16'd0;
    end else if (key_load) begin
      // A byte accepted this cycle was already decrypted with the old key
      state_reg      <= RUN;
      lfsr_reg       <= seed_fixed;
      byte_count_reg <= 16'd0;
    end else if (accept) begin
      lfsr_reg       <= lfsr_next(lfsr_reg);
      byte_count_reg <= byte_count_reg + 16'd1;
    end
  end

`ifdef VERNAM_DEC_CHECKSUM_EN
  logic [7:0] checksum_reg;

  // Running XOR over plaintext accepted since the last key change
  always_ff @(posedge clk) begin
    if (reset || key_clear || key_load) begin
      checksum_reg <= 8'h00;
    end else if (accept) begin
      checksum_reg <= checksum_reg ^ plain;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 8'h00;
`endif

  vernam_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (key_clear),
    .push    (accept),
    .wr_data (plain),
    .pop     (out_ready),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_vernam_decrypt.sv
// tb_vernam_decrypt: directed and randomized checks of vernam_decrypt
// against a queue-based behavioural model of the decryptor.
module tb_vernam_decrypt;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_load;
  logic [7:0]  key_seed;
  logic        key_clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] byte_count;
  logic [7:0]  checksum;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_run;
  logic [7:0]  m_ks;
  logic [7:0]  m_q[$];
  logic [15:0] m_count;
  logic [7:0]  m_csum;

  always #5 clk = ~clk;

  vernam_decrypt #(.DEPTH(DEPTH), .SEED_DEFAULT(8'h01)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_load   (key_load),
    .key_seed   (key_seed),
    .key_clear  (key_clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  // Keystream step from the rule: double, drop overflow, add feedback bit
  function automatic logic [7:0] ks_step(input logic [7:0] s);
    int fb;
    fb = (s[7] + s[5] + s[4] + s[3]) % 2;
    return 8'(((int'(s) * 2) % 256) + fb);
  endfunction

  function automatic logic [7:0] exp_checksum();
`ifdef VERNAM_DEC_CHECKSUM_EN
    return m_csum;
`else
    return 8'h00;
`endif
  endfunction

  // Drive one clock of stimulus and advance the model for that edge
  task automatic drive_cycle(input bit iv, input logic [7:0] d, input bit ordy,
                             input bit kl, input logic [7:0] seed, input bit kc);
    bit acc, pop;
    logic [7:0] p;
    in_valid = iv; in_data = d; out_ready = ordy;
    key_load = kl; key_seed = seed; key_clear = kc;
    @(negedge clk);
    acc = iv && m_run && (m_q.size() < DEPTH) && !kc;
    pop = ordy && (m_q.size() > 0);
    p   = d ^ m_ks;
    if (acc) $display("txn in=%h ks=%h plain=%h kl=%0d", d, m_ks, p, kl);
    if (kc) begin
      m_q.delete(); m_run = 0; m_count = 0; m_csum = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(p);
      if (kl) begin
        m_run = 1; m_ks = (seed == 8'h00) ? 8'h01 : seed; m_count = 0; m_csum = 0;
      end else if (acc) begin
        m_ks = ks_step(m_ks); m_count = m_count + 16'd1; m_csum = m_csum ^ p;
      end
    end
    @(posedge clk); #1;
    in_valid = 0; key_load = 0; key_clear = 0;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; in_data = 0; out_ready = 0;
    key_load = 0; key_seed = 0; key_clear = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_run = 0; m_ks = 8'h01; m_q.delete(); m_count = 0; m_csum = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_checks++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL reset_byte_count got %0d want 0", byte_count); end
    n_checks++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL reset_checksum got %h want 00", checksum); end
  endtask

  task automatic test_basic();
    logic [7:0] cin [4];
    logic [7:0] pexp [4];
    cin  = '{8'h40, 8'h02, 8'h06, 8'h0A};
    pexp = '{8'h41, 8'h00, 8'h02, 8'h02};
    do_reset();
    drive_cycle(0, 8'h00, 1, 1, 8'h01, 0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_load got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, cin[i], 1, 0, 8'h00, 0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== pexp[i]) begin
        n_fail++; $display("FAIL basic_out%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, pexp[i]);
      end
    end
    n_checks++; if (byte_count !== 16'd4) begin n_fail++; $display("FAIL basic_byte_count got %0d want 4", byte_count); end
`ifdef VERNAM_DEC_CHECKSUM_EN
    n_checks++; if (checksum !== 8'h41) begin n_fail++; $display("FAIL basic_checksum got %h want 41", checksum); end
`else
    n_checks++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL basic_checksum got %h want 00", checksum); end
`endif
  endtask

  task automatic test_seed_zero();
    do_reset();
    drive_cycle(0, 8'h00, 1, 1, 8'h00, 0);
    drive_cycle(1, 8'h01, 1, 0, 8'h00, 0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("FAIL seed0_first got v=%b d=%h want v=1 d=00", out_valid, out_data); end
    drive_cycle(1, 8'h06, 1, 0, 8'h00, 0);
    n_checks++; if (out_data !== 8'h04) begin n_fail++; $display("FAIL seed0_second got %h want 04", out_data); end
  endtask

  task automatic test_backpressure();
    logic [7:0] pexp [4];
    pexp = '{8'h11, 8'h22, 8'h34, 8'h48};
    do_reset();
    drive_cycle(0, 8'h00, 0, 1, 8'h01, 0);
    for (int i = 0; i < 6; i++) drive_cycle(1, 8'((i + 1) * 16), 0, 0, 8'h00, 0);
    n_checks++; if (byte_count !== 16'd4) begin n_fail++; $display("FAIL bp_accepts got %0d want 4", byte_count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== pexp[i]) begin
        n_fail++; $display("FAIL bp_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, pexp[i]);
      end
      drive_cycle(0, 8'h00, 1, 0, 8'h00, 0);
      if (i == 0) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
      end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_key_load_accept();
    do_reset();
    drive_cycle(0, 8'h00, 1, 1, 8'h01, 0);
    drive_cycle(1, 8'hAA, 1, 0, 8'h00, 0);
    drive_cycle(1, 8'hBB, 1, 0, 8'h00, 0);
    drive_cycle(1, 8'h44, 1, 1, 8'h01, 0);
    n_checks++; if (out_data !== 8'h40) begin n_fail++; $display("FAIL kla_out got %h want 40", out_data); end
    n_checks++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL kla_count0 got %0d want 0", byte_count); end
    drive_cycle(1, 8'h55, 1, 0, 8'h00, 0);
    n_checks++; if (out_data !== 8'h54) begin n_fail++; $display("FAIL kla_next got %h want 54", out_data); end
    n_checks++; if (byte_count !== 16'd1) begin n_fail++; $display("FAIL kla_count1 got %0d want 1", byte_count); end
  endtask

  task automatic test_key_clear();
    do_reset();
    drive_cycle(0, 8'h00, 0, 1, 8'h01, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 8'($urandom), 0, 0, 8'h00, 0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL kc_pre_valid got %b want 1", out_valid); end
    drive_cycle(0, 8'h00, 0, 0, 8'h00, 1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kc_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kc_in_ready got %b want 0", in_ready); end
    n_checks++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL kc_byte_count got %0d want 0", byte_count); end
    n_checks++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL kc_checksum got %h want 00", checksum); end
    drive_cycle(0, 8'h00, 0, 1, 8'h07, 0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kc_reload_ready got %b want 1", in_ready); end
    drive_cycle(1, 8'h33, 0, 1, 8'h07, 1);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kc_kl_idle got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kc_kl_no_accept got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    bit iv, ordy, kl, kc;
    logic [7:0] seed;
    do_reset();
    drive_cycle(0, 8'h00, 1, 1, 8'($urandom_range(1, 255)), 0);
    for (int c = 0; c < 300; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      kl   = ($urandom_range(0, 39) == 0);
      kc   = ($urandom_range(0, 59) == 0);
      seed = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (!m_run && $urandom_range(0, 3) == 0) kl = 1;
      drive_cycle(iv, 8'($urandom), ordy, kl, seed, kc);
      n_checks++;
      if (in_ready !== (m_run && m_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, (m_run && m_q.size() < DEPTH));
      end
      n_checks++;
      if (out_valid !== (m_q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, (m_q.size() > 0));
      end
      if (m_q.size() > 0) begin
        n_checks++;
        if (out_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_out_data cyc %0d got %h want %h", c, out_data, m_q[0]); end
      end
      n_checks++;
      if (byte_count !== m_count) begin n_fail++; $display("FAIL rnd_byte_count cyc %0d got %0d want %0d", c, byte_count, m_count); end
      n_checks++;
      if (checksum !== exp_checksum()) begin n_fail++; $display("FAIL rnd_checksum cyc %0d got %h want %h", c, checksum, exp_checksum()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed_zero();
    test_backpressure();
    test_key_load_accept();
    test_key_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vernam_decrypt.md
# vernam_decrypt

Receive-side Vernam block: accepts ciphertext bytes from the encrypting end, regenerates the same 8-bit keystream from a shared seed, XORs to recover plaintext and buffers the result for a downstream consumer. Sits opposite the cipher/random Picoblaze pair. Replaces a software decrypt loop with a streaming datapath at one byte per clock.

## Interface
Parameters:
- DEPTH, 4: output FIFO entries, power of two, 2..16
- SEED_DEFAULT, 8'h01: LFSR value loaded by reset

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- key_load  in  1  one-cycle pulse; loads key_seed into the LFSR and enters RUN
- key_seed  in  8  seed; 8'h00 is replaced by 8'h01
- key_clear  in  1  one-cycle pulse; return to IDLE and flush the FIFO
- in_data  in  8  ciphertext byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  8  plaintext byte (FIFO head)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer takes out_data this cycle
- byte_count  out  16  plaintext bytes accepted since last key_load, wraps
- checksum  out  8  running XOR of plaintext bytes (see Configuration)

## Operation
- States: IDLE (no key, in_ready=0) and RUN.
- IDLE -> RUN on key_load. RUN -> IDLE on key_clear. key_load in RUN reseeds without leaving RUN.
- in_ready = (state==RUN) && !fifo_full && !key_clear.
- An accept is in_valid && in_ready. On accept: push in_data ^ lfsr, advance LFSR one step, byte_count += 1.
- LFSR is Fibonacci, left shift: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Keystream byte = current state. From 8'h01 the sequence is 01, 02, 04, 08, 11, 23.
- key_load in the same cycle as an accept: the byte is decrypted with the old keystream byte, then the LFSR loads the seed. byte_count is cleared to 0, so the accepted byte is not counted. checksum is cleared.
- key_clear has priority over key_load in the same cycle. key_clear flushes the FIFO, clears byte_count and checksum, and leaves the LFSR unchanged.
- FIFO: push and pop in the same cycle are both allowed when the FIFO is full. The pop frees the slot, but in_ready still reflects the full state, so no accept happens that cycle. No overflow or underflow is possible.

## Timing
- Reset values:
  - state = IDLE, lfsr = SEED_DEFAULT, FIFO empty
  - in_ready = 0, out_valid = 0, out_data = 0
  - byte_count = 0, checksum = 0
- Latency: a byte accepted at edge N is visible on out_data with out_valid=1 after edge N when the FIFO was empty. The FIFO is show-ahead with a registered head.
- Throughput: 1 byte per clk with out_ready held high.
- key_load takes effect at the next edge, so in_ready can rise the cycle after the pulse.
- Reset mid-stream discards all FIFO content and the key.

## Configuration
- VERNAM_DEC_CHECKSUM_EN defined: checksum is updated on every accept with checksum ^= plaintext byte.
- VERNAM_DEC_CHECKSUM_EN undefined: the checksum port is tied to 8'h00 and no checksum register is synthesized.

## Structure
- vernam_pkg holds:
  - state enum {IDLE, RUN}
  - LFSR tap constants
  - SEED_DEFAULT value
  - function lfsr_next(8-bit)
- vernam_pkg is shared with the encrypt side so both ends use one keystream definition.
- Sub-module vernam_fifo (parameter DEPTH, 8-bit, show-ahead, full/empty flags).

## Test plan
- Reset, then key_load seed 8'h01 and send 40,02,06,0A with out_ready=1:
  - out_data is 41,00,02,02 on consecutive cycles
  - byte_count = 4
- key_seed 8'h00: behaves identically to seed 8'h01. First ciphertext 8'h01 gives plaintext 8'h00.
- out_ready=0 with DEPTH=4 and in_valid held high:
  - exactly 4 accepts, then in_ready=0
  - raising out_ready drains in order and in_ready reasserts after the first pop
- key_load coincident with an accept (seed 8'h01, LFSR at 8'h04, in 8'h44):
  - output 8'h40
  - next accepted byte is XORed with 8'h01
  - byte_count = 1 after that byte
- key_clear while the FIFO holds 3 bytes:
  - out_valid=0 and in_ready=0 the next cycle, byte_count = 0
  - key_clear together with key_load in the same cycle leaves the block in IDLE
- With VERNAM_DEC_CHECKSUM_EN: plaintext 41,00,02,02 gives checksum 8'h41. Without the macro: checksum stays 8'h00.
